// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
//   rx_state_t  : receiver FSM state encoding
//   Oversample  : oversample ticks per bit
//   VoteLo/SampleMid/VoteHi : sample indices used for the 3-point majority vote
//   majority3() : 2-of-3 vote helper
package uart_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t StIdle  = 2'd0;
  localparam rx_state_t StStart = 2'd1;
  localparam rx_state_t StData  = 2'd2;
  localparam rx_state_t StStop  = 2'd3;

  localparam int unsigned Oversample = 16;
  localparam int unsigned SampleW    = $clog2(Oversample);

  typedef logic [SampleW-1:0] sample_idx_t;

  localparam sample_idx_t VoteLo     = sample_idx_t'(7);
  localparam sample_idx_t SampleMid  = sample_idx_t'(8);
  localparam sample_idx_t VoteHi     = sample_idx_t'(9);
  localparam sample_idx_t SampleLast = sample_idx_t'(Oversample - 1);

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the UART receiver and transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count from 0 (phase alignment)
//   div_i      : clk cycles per tick; 0 behaves as 1
//   tick_o     : one-cycle pulse on the terminal count
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d, term;
  logic             wrap;

  always_comb begin
    term   = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    // >= rather than == so a divisor lowered mid-count wraps at once instead of rolling over.
    wrap   = (cnt_q >= term);
    tick_o = wrap & ~clr_i;
    if (clr_i || wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive front end: 16x oversampling, 2-of-3 vote per bit, 8N1 framing (LSB first),
// valid/ready byte output with one-cycle frame_err and overrun pulses.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : low holds the receiver idle (output handshake stays live)
//   rx_i                : asynchronous serial line, idles high
//   baud_div            : clk cycles per oversample tick (0 treated as 1)
//   rx_data, rx_valid   : received byte, held until rx_valid & rx_ready
//   rx_ready            : consumer accept
//   frame_err, overrun  : one-cycle event pulses
module uart_rx_core #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx_i,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);
  import uart_pkg::*;

  localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

  // Synchroniser, edge history and line-arming
  logic       rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0] warm_q;
  logic       armed_q;

  // A start edge is only trusted once the synchroniser carries real line data and the line
  // has been seen high; otherwise a reset released mid-frame would fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      warm_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      warm_q    <= {warm_q[0], 1'b1};
      armed_q   <= armed_q | (warm_q[1] & rx_s_q);
    end
  end

  rx_state_t            state_q, state_d;
  sample_idx_t          samp_q, samp_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic start_edge, clr, tick, vote, at_vote, at_end, byte_done, stop_err;

  assign start_edge = ena & armed_q & (state_q == StIdle) & rx_prev_q & ~rx_s_q;
  assign clr        = start_edge | ~ena;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .div_i (baud_div),
    .tick_o(tick)
  );

  assign vote    = majority3(vote_q[0], vote_q[1], rx_s_q);
  assign at_vote = tick & (samp_q == VoteHi);
  assign at_end  = tick & (samp_q == SampleLast);

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_cnt_d = bit_cnt_q;
    vote_d    = vote_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;

    if (clr) begin
      samp_d = '0;
    end else if (tick) begin
      samp_d = samp_q + sample_idx_t'(1);
    end

    if (tick && samp_q == VoteLo) begin
      vote_d[0] = rx_s_q;
    end
    if (tick && samp_q == SampleMid) begin
      vote_d[1] = rx_s_q;
    end

    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (at_vote && vote) begin
          state_d = StIdle;
        end else if (at_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
        end
        if (at_end) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StStop: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        if (at_vote) begin
          state_d   = StIdle;
          byte_done = vote;
          stop_err  = ~vote;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StData) begin
      bit_cnt_d = '0;
    end
    if (!ena) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_err;
    overrun_d   = 1'b0;
    if (byte_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      samp_q      <= '0;
      bit_cnt_q   <= '0;
      vote_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      bit_cnt_q   <= bit_cnt_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
